vdma_ex_timing_gen: RTL and testbench

VDMA_EX_TIMING_GEN -- requirements
Module: vdma_ex_timing_gen

---
 rtl/vdma_vtg_pkg.sv | 46 ++++
 rtl/vdma_ex_timing_gen.sv | 126 ++++++++++++
 tb/tb_vdma_ex_timing_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/vdma_vtg_pkg.sv
// rtl/vdma_vtg_pkg.sv - timing set, format constants, format decode and FSM state enum
package vdma_vtg_pkg;

  typedef struct packed {
    logic [15:0] htotal;
    logic [15:0] hactive;
    logic [15:0] hfp;
    logic [15:0] hsync;
    logic [15:0] vtotal;
    logic [15:0] vactive;
    logic [15:0] vfp;
    logic [15:0] vsync;
  } vtg_timing_t;

  typedef enum logic [1:0] {
    VTG_IDLE  = 2'd0,
    VTG_RUN   = 2'd1,
    VTG_DRAIN = 2'd2
  } vtg_state_e;

  localparam logic [63:0] VTG_FMT_1080P60 = "1080P@60";
  localparam logic [63:0] VTG_FMT_720P60  = {8'h00, "720P@60"};
  localparam logic [63:0] VTG_FMT_480P60  = {8'h00, "480P@60"};

  localparam vtg_timing_t VTG_1080P60 = '{htotal: 16'd2200, hactive: 16'd1920, hfp: 16'd88,
                                          hsync: 16'd44, vtotal: 16'd1125, vactive: 16'd1080,
                                          vfp: 16'd4, vsync: 16'd5};
  localparam vtg_timing_t VTG_720P60  = '{htotal: 16'd1650, hactive: 16'd1280, hfp: 16'd110,
                                          hsync: 16'd40, vtotal: 16'd750, vactive: 16'd720,
                                          vfp: 16'd5, vsync: 16'd5};
  localparam vtg_timing_t VTG_480P60  = '{htotal: 16'd800, hactive: 16'd640, hfp: 16'd16,
                                          hsync: 16'd96, vtotal: 16'd525, vactive: 16'd480,
                                          vfp: 16'd10, vsync: 16'd2};

  function automatic logic vtg_fmt_legal(input logic [63:0] fmt);
    return (fmt == VTG_FMT_1080P60) || (fmt == VTG_FMT_720P60) || (fmt == VTG_FMT_480P60);
  endfunction

  // Unknown strings fall back to 1080P; legality is enforced separately at elaboration.
  function automatic vtg_timing_t vtg_timing(input logic [63:0] fmt);
    if (fmt == VTG_FMT_480P60) return VTG_480P60;
    if (fmt == VTG_FMT_720P60) return VTG_720P60;
    return VTG_1080P60;
  endfunction

endpackage

// File: rtl/vdma_ex_timing_gen.sv
// rtl/vdma_ex_timing_gen.sv - video timing generator with IDLE/RUN/DRAIN frame control
// Optional frame counter output enabled by macro VDMA_VTG_FRAME_CNT_EN.
module vdma_ex_timing_gen
  import vdma_vtg_pkg::*;
#(
  parameter logic [63:0] VIDEO_FORMAT = "1080P@60"
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        enable,
  output logic        vsync,
  output logic        hsync,
  output logic        de,
  output logic [15:0] vactive,
  output logic [15:0] hactive,
  output logic        frame_start,
  output logic        busy
`ifdef VDMA_VTG_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam vtg_timing_t T        = vtg_timing(VIDEO_FORMAT);
  localparam logic [15:0] H_LAST   = T.htotal - 16'd1;
  localparam logic [15:0] V_LAST   = T.vtotal - 16'd1;
  localparam logic [15:0] HS_START = T.hactive + T.hfp;
  localparam logic [15:0] HS_END   = HS_START + T.hsync;
  localparam logic [15:0] VS_START = T.vactive + T.vfp;
  localparam logic [15:0] VS_END   = VS_START + T.vsync;

  if (!vtg_fmt_legal(VIDEO_FORMAT)) begin : g_bad_format
    $error("vdma_ex_timing_gen: illegal VIDEO_FORMAT");
  end

  vtg_state_e  state_q, state_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [15:0] vcnt_q, vcnt_d;
  logic        vsync_q, vsync_d;
  logic        hsync_q, hsync_d;
  logic        de_q, de_d;
  logic        frame_start_q, frame_start_d;
  logic        busy_q, busy_d;
  logic        h_last, v_last, in_frame;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q       <= VTG_IDLE;
      hcnt_q        <= 16'd0;
      vcnt_q        <= 16'd0;
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      vsync_q       <= vsync_d;
      hsync_q       <= hsync_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    h_last   = (hcnt_q == H_LAST);
    v_last   = (vcnt_q == V_LAST);
    in_frame = (state_q == VTG_RUN) || (state_q == VTG_DRAIN);

    unique case (state_q)
      VTG_IDLE: begin
        hcnt_d = 16'd0;
        vcnt_d = 16'd0;
        if (enable) state_d = VTG_RUN;
      end
      VTG_RUN, VTG_DRAIN: begin
        // At frame end a low enable stops cleanly; otherwise the next frame follows seamlessly.
        if (h_last && v_last) state_d = enable ? VTG_RUN : VTG_IDLE;
        else                  state_d = enable ? VTG_RUN : VTG_DRAIN;
        hcnt_d = h_last ? 16'd0 : hcnt_q + 16'd1;
        if (h_last) vcnt_d = v_last ? 16'd0 : vcnt_q + 16'd1;
      end
      default: begin
        state_d = VTG_IDLE;
        hcnt_d  = 16'd0;
        vcnt_d  = 16'd0;
      end
    endcase

    de_d          = in_frame && (hcnt_q < T.hactive) && (vcnt_q < T.vactive);
    hsync_d       = in_frame && (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    vsync_d       = in_frame && (vcnt_q >= VS_START) && (vcnt_q < VS_END);
    frame_start_d = (state_q == VTG_RUN) && (hcnt_q == 16'd0) && (vcnt_q == 16'd0);
    busy_d        = in_frame;
  end

`ifdef VDMA_VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) frame_cnt_q <= 16'd0;
    else         frame_cnt_q <= frame_cnt_d;
  end

  always_comb begin
    frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign vsync       = vsync_q;
  assign hsync       = hsync_q;
  assign de          = de_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign vactive     = T.vactive;
  assign hactive     = T.hactive;

endmodule

// File: tb/tb_vdma_ex_timing_gen.sv
// tb/tb_vdma_ex_timing_gen.sv - randomized bench for all three formats against a frame-position model
module tb_vdma_ex_timing_gen;

  logic       pclk;
  logic       prst_n;
  logic [2:0] en;
  logic       chk_on;
  int         checks;
  int         errors;

  logic        vs_w [3];
  logic        hs_w [3];
  logic        de_w [3];
  logic        fs_w [3];
  logic        bz_w [3];
  logic [15:0] va_w [3];
  logic [15:0] ha_w [3];
`ifdef VDMA_VTG_FRAME_CNT_EN
  logic [15:0] fc_w [3];
  int          e_fc [3];
`endif

  // Index 0 = 480P@60, 1 = 720P@60, 2 = 1080P@60
  int HT  [3] = '{800, 1650, 2200};
  int HA  [3] = '{640, 1280, 1920};
  int HFP [3] = '{16, 110, 88};
  int HSW [3] = '{96, 40, 44};
  int VT  [3] = '{525, 750, 1125};
  int VA  [3] = '{480, 720, 1080};
  int VFP [3] = '{10, 5, 4};
  int VSW [3] = '{2, 5, 5};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [63:0] FMT = (g == 0) ? {8'h00, "480P@60"} :
                                  (g == 1) ? {8'h00, "720P@60"} : "1080P@60";
    vdma_ex_timing_gen #(.VIDEO_FORMAT(FMT)) u_dut (
      .pclk        (pclk),
      .prst_n      (prst_n),
      .enable      (en[g]),
      .vsync       (vs_w[g]),
      .hsync       (hs_w[g]),
      .de          (de_w[g]),
      .vactive     (va_w[g]),
      .hactive     (ha_w[g]),
      .frame_start (fs_w[g]),
      .busy        (bz_w[g])
`ifdef VDMA_VTG_FRAME_CNT_EN
      ,
      .frame_cnt   (fc_w[g])
`endif
    );
  end

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 25) $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a frame is a run of HT*VT cycles indexed by pos; once started it always completes.
  bit act [3];
  int pos [3];
  bit e_de [3], e_hs [3], e_vs [3], e_fs [3], e_bz [3];

  always @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      for (int k = 0; k < 3; k++) begin
        act[k] <= 0; pos[k] <= 0;
        e_de[k] <= 0; e_hs[k] <= 0; e_vs[k] <= 0; e_fs[k] <= 0; e_bz[k] <= 0;
`ifdef VDMA_VTG_FRAME_CNT_EN
        e_fc[k] <= 0;
`endif
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        e_bz[k] <= act[k];
        e_fs[k] <= act[k] && pos[k] == 0;
        e_de[k] <= act[k] && (pos[k] % HT[k]) < HA[k] && (pos[k] / HT[k]) < VA[k];
        e_hs[k] <= act[k] && (pos[k] % HT[k]) >= HA[k] + HFP[k]
                          && (pos[k] % HT[k]) <  HA[k] + HFP[k] + HSW[k];
        e_vs[k] <= act[k] && (pos[k] / HT[k]) >= VA[k] + VFP[k]
                          && (pos[k] / HT[k]) <  VA[k] + VFP[k] + VSW[k];
`ifdef VDMA_VTG_FRAME_CNT_EN
        if (act[k] && pos[k] == 0) e_fc[k] <= (e_fc[k] + 1) % 65536;
`endif
        if (!act[k]) begin
          act[k] <= en[k];
          pos[k] <= 0;
        end else if (pos[k] == HT[k] * VT[k] - 1) begin
          act[k] <= en[k];
          pos[k] <= 0;
        end else begin
          pos[k] <= pos[k] + 1;
        end
      end
    end
  end

  always @(negedge pclk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("de%0d", k),    32'(de_w[k]), 32'(e_de[k]));
        check($sformatf("hsync%0d", k), 32'(hs_w[k]), 32'(e_hs[k]));
        check($sformatf("vsync%0d", k), 32'(vs_w[k]), 32'(e_vs[k]));
        check($sformatf("fstart%0d", k), 32'(fs_w[k]), 32'(e_fs[k]));
        check($sformatf("busy%0d", k),  32'(bz_w[k]), 32'(e_bz[k]));
        check($sformatf("vactive%0d", k), 32'(va_w[k]), VA[k]);
        check($sformatf("hactive%0d", k), 32'(ha_w[k]), HA[k]);
`ifdef VDMA_VTG_FRAME_CNT_EN
        check($sformatf("frame_cnt%0d", k), 32'(fc_w[k]), e_fc[k]);
`endif
      end
    end
  end

  task automatic wait_fs(input int k, input int limit, output int n);
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!fs_w[k] && n < limit);
  endtask

  task automatic pulse_reset_and_check();
    @(negedge pclk);
    #2 prst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_zero%0d", k),
            {27'd0, de_w[k], hs_w[k], vs_w[k], fs_w[k], bz_w[k]}, 32'd0);
    end
    @(negedge pclk);
    prst_n = 1'b1;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    chk_on = 1'b0;
    prst_n = 1'b0;
    en     = 3'b000;
    repeat (3) @(negedge pclk);
    chk_on = 1'b1;
    prst_n = 1'b1;
    repeat (10) @(negedge pclk);

    // Start from idle: frame_start one cycle after the first RUN cycle.
    en = 3'b111;
    wait_fs(0, 50, n);
    check("fs_latency_start", n, 2);

    // Enable dropped and re-raised mid-frame on every format: frame continues, no extra start.
    repeat (5 * 800) @(negedge pclk);
    en = 3'b000;
    repeat (5 * 800) @(negedge pclk);
    en = 3'b111;
    repeat (5 * 800) @(negedge pclk);

    // Reset mid-frame aborts at once; restart after release with enable high.
    pulse_reset_and_check();
    wait_fs(2, 50, n);
    check("fs_latency_reset", n, 2);

    for (int s = 0; s < 12; s++) begin
      en = 3'($urandom_range(0, 7));
      repeat ($urandom_range(20, 2000)) @(negedge pclk);
      if ($urandom_range(0, 5) == 0) pulse_reset_and_check();
    end

    en = 3'b000;
    repeat (20) @(negedge pclk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
